// File: rtl/vgm_gbdmg_player_pkg.sv
// Shared opcode constants, wait lengths and FSM state encoding for the VGM GB DMG player.
package vgm_gbdmg_player_pkg;

  localparam logic [7:0] OP_GB_WRITE      = 8'hB3;
  localparam logic [7:0] OP_WAIT_N        = 8'h61;
  localparam logic [7:0] OP_WAIT_60       = 8'h62;
  localparam logic [7:0] OP_WAIT_50       = 8'h63;
  localparam logic [7:0] OP_END           = 8'h66;
  localparam logic [3:0] OP_WAIT_SHORT_HI = 4'h7;

  localparam logic [15:0] WAIT_60HZ = 16'd735;
  localparam logic [15:0] WAIT_50HZ = 16'd882;

  typedef enum logic [3:0] {
    S_OP, S_ADDR, S_DATA, S_WRITE, S_GAP,
    S_W_LO, S_W_HI, S_WAIT, S_DONE, S_ERR
  } state_t;

  // States in which a stream byte may be consumed.
  function automatic logic takes_byte(state_t s);
    return (s == S_OP) || (s == S_ADDR) || (s == S_DATA) ||
           (s == S_W_LO) || (s == S_W_HI);
  endfunction

endpackage

// File: rtl/vgm_sample_tick.sv
// Sample-rate divider: one-cycle tick every SAMPLE_DIV clocks, restarted by a synchronous clear.
module vgm_sample_tick #(
  parameter int SAMPLE_DIV = 544
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(SAMPLE_DIV);
  localparam logic [W-1:0] LAST = W'(SAMPLE_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/vgm_gbdmg_player.sv
// VGM command sequencer driving the DMG APU register-write port (0xB3 writes, 0x61-0x63/0x7n waits).
module vgm_gbdmg_player
  import vgm_gbdmg_player_pkg::*;
#(
  parameter int SAMPLE_DIV = 544
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  output logic [5:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_err
);

  state_t      state;
  logic [7:0]  aa;
  logic [7:0]  lo;
  logic [15:0] cnt;
  logic        hs;
  logic        tick;

  assign out_ready = takes_byte(state);
  assign hs        = in_valid && out_ready;

  // Strobe and status decode straight from state so reset drops them without waiting for a clock.
  assign out_wr   = (state == S_WRITE);
  assign out_busy = (state == S_WAIT);
  assign out_done = (state == S_DONE);
  assign out_err  = (state == S_ERR);

  vgm_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (in_clk),
    .rst  (in_rst),
    .clr  (state != S_WAIT),
    .tick (tick)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state   <= S_OP;
      aa      <= '0;
      lo      <= '0;
      cnt     <= '0;
      out_reg <= '0;
      out_val <= '0;
    end else begin
      case (state)
        S_OP: if (hs) begin
          if (in_data == OP_GB_WRITE)      state <= S_ADDR;
          else if (in_data == OP_WAIT_N)   state <= S_W_LO;
          else if (in_data == OP_WAIT_60) begin
            cnt   <= WAIT_60HZ;
            state <= S_WAIT;
          end else if (in_data == OP_WAIT_50) begin
            cnt   <= WAIT_50HZ;
            state <= S_WAIT;
          end else if (in_data[7:4] == OP_WAIT_SHORT_HI) begin
            cnt   <= {12'd0, in_data[3:0]} + 16'd1;
            state <= S_WAIT;
          end else if (in_data == OP_END)  state <= S_DONE;
          else                             state <= S_ERR;
        end
        S_ADDR: if (hs) begin
          aa    <= in_data;
          state <= S_DATA;
        end
        S_DATA: if (hs) begin
          // Registers beyond the 6-bit APU window are dropped without a strobe.
          if (aa[7:6] == 2'b00) begin
            out_reg <= aa[5:0];
            out_val <= in_data;
            state   <= S_WRITE;
          end else begin
            state   <= S_OP;
          end
        end
        S_WRITE: state <= S_GAP;
        S_GAP:   state <= S_OP;
        S_W_LO: if (hs) begin
          lo    <= in_data;
          state <= S_W_HI;
        end
        S_W_HI: if (hs) begin
          if ({in_data, lo} == 16'd0) state <= S_OP;
          else begin
            cnt   <= {in_data, lo};
            state <= S_WAIT;
          end
        end
        S_WAIT: if (tick) begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) state <= S_OP;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_vgm_gbdmg_player.sv
// Directed bench for vgm_gbdmg_player with SAMPLE_DIV=4; a negedge monitor logs strobes and busy cycles.
module tb_vgm_gbdmg_player;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready, out_wr, out_busy, out_done, out_err;
  logic [5:0] out_reg;
  logic [7:0] out_val;

  vgm_gbdmg_player #(.SAMPLE_DIV(4)) dut (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .out_reg  (out_reg),
    .out_val  (out_val),
    .out_wr   (out_wr),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_err  (out_err)
  );

  always #5 in_clk = ~in_clk;

  int chk = 0;
  int pass = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int dbl = 0;
  int last_post = 0;
  logic prev_wr = 1'b0;
  logic [5:0] wr_reg_q[$];
  logic [7:0] wr_val_q[$];
  int         wr_cyc_q[$];

  always @(posedge in_clk) cyc++;

  always @(negedge in_clk) begin
    if (out_wr) begin
      wr_reg_q.push_back(out_reg);
      wr_val_q.push_back(out_val);
      wr_cyc_q.push_back(cyc);
    end
    if (out_wr && prev_wr) dbl++;
    prev_wr = out_wr;
    if (out_busy) busy_cnt++;
  end

  task automatic clear_log();
    wr_reg_q.delete();
    wr_val_q.delete();
    wr_cyc_q.delete();
    busy_cnt = 0;
    dbl = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  // Present one byte and hold it until accepted; returns #1 after the transfer edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!out_ready && n < 5000) begin
      @(posedge in_clk);
      #1;
      n++;
    end
    if (!out_ready) begin
      chk++;
      $display("FAIL send_timeout byte=%02h ready never rose", b);
    end else begin
      @(posedge in_clk);
      #1;
      last_post = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (out_busy && n < 10000) begin
      @(posedge in_clk);
      #1;
      n++;
    end
    if (out_busy) begin
      chk++;
      $display("FAIL wait_timeout busy still high");
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_rst = 1'b1;
    idle(2);
    in_rst = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    #3;
    chk++; if (out_wr !== 1'b0)    $display("FAIL rst_wr got %b want 0", out_wr);    else pass++;
    chk++; if (out_busy !== 1'b0)  $display("FAIL rst_busy got %b want 0", out_busy); else pass++;
    chk++; if (out_done !== 1'b0)  $display("FAIL rst_done got %b want 0", out_done); else pass++;
    chk++; if (out_err !== 1'b0)   $display("FAIL rst_err got %b want 0", out_err);   else pass++;
    chk++; if (out_reg !== 6'h00)  $display("FAIL rst_reg got %h want 00", out_reg);  else pass++;
    chk++; if (out_val !== 8'h00)  $display("FAIL rst_val got %h want 00", out_val);  else pass++;
    chk++; if (out_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", out_ready); else pass++;
    do_reset();
  endtask

  task automatic test_single_write();
    int post;
    clear_log();
    send(8'hB3); send(8'h01); send(8'h80);
    post = last_post;
    idle(4);
    chk++; if (wr_cyc_q.size() !== 1) $display("FAIL single_count got %0d want 1", wr_cyc_q.size()); else pass++;
    if (wr_cyc_q.size() == 1) begin
      chk++; if (wr_reg_q[0] !== 6'h01) $display("FAIL single_reg got %h want 01", wr_reg_q[0]); else pass++;
      chk++; if (wr_val_q[0] !== 8'h80) $display("FAIL single_val got %h want 80", wr_val_q[0]); else pass++;
      chk++; if (wr_cyc_q[0] !== post)  $display("FAIL single_lat got %0d want %0d", wr_cyc_q[0], post); else pass++;
    end
    chk++; if (dbl !== 0) $display("FAIL single_width got %0d wide pulses want 0", dbl); else pass++;
    chk++; if (out_val !== 8'h80) $display("FAIL single_hold got %h want 80", out_val); else pass++;
  endtask

  task automatic test_back_to_back();
    clear_log();
    send(8'hB3); send(8'h03); send(8'h11);
    send(8'hB3); send(8'h04); send(8'h87);
    idle(4);
    chk++; if (wr_cyc_q.size() !== 2) $display("FAIL b2b_count got %0d want 2", wr_cyc_q.size()); else pass++;
    if (wr_cyc_q.size() == 2) begin
      chk++; if (wr_reg_q[0] !== 6'h03 || wr_val_q[0] !== 8'h11)
        $display("FAIL b2b_first got %h/%h want 03/11", wr_reg_q[0], wr_val_q[0]); else pass++;
      chk++; if (wr_reg_q[1] !== 6'h04 || wr_val_q[1] !== 8'h87)
        $display("FAIL b2b_second got %h/%h want 04/87", wr_reg_q[1], wr_val_q[1]); else pass++;
      chk++; if (wr_cyc_q[1] - wr_cyc_q[0] !== 5)
        $display("FAIL b2b_spacing got %0d want 5", wr_cyc_q[1] - wr_cyc_q[0]); else pass++;
    end
    chk++; if (dbl !== 0) $display("FAIL b2b_width got %0d want 0", dbl); else pass++;
  endtask

  task automatic test_wait_n();
    clear_log();
    send(8'h61); send(8'h03); send(8'h00);
    send(8'hB3); send(8'h02); send(8'h55);
    idle(4);
    chk++; if (busy_cnt !== 12) $display("FAIL waitn_busy got %0d want 12", busy_cnt); else pass++;
    chk++; if (wr_cyc_q.size() !== 1) $display("FAIL waitn_count got %0d want 1", wr_cyc_q.size()); else pass++;
    if (wr_cyc_q.size() == 1) begin
      chk++; if (wr_reg_q[0] !== 6'h02 || wr_val_q[0] !== 8'h55)
        $display("FAIL waitn_write got %h/%h want 02/55", wr_reg_q[0], wr_val_q[0]); else pass++;
    end
    // Zero-length wait: next opcode is taken on the very next cycle.
    clear_log();
    send(8'h61); send(8'h00); send(8'h00);
    chk++; if (out_ready !== 1'b1 || out_busy !== 1'b0)
      $display("FAIL wait0_state got ready=%b busy=%b want 1/0", out_ready, out_busy); else pass++;
    idle(3);
    chk++; if (busy_cnt !== 0) $display("FAIL wait0_busy got %0d want 0", busy_cnt); else pass++;
  endtask

  task automatic test_wait_short();
    clear_log();
    send(8'h7F); wait_idle(); idle(1);
    chk++; if (busy_cnt !== 64) $display("FAIL wait7f_busy got %0d want 64", busy_cnt); else pass++;
    clear_log();
    send(8'h70); wait_idle(); idle(1);
    chk++; if (busy_cnt !== 4) $display("FAIL wait70_busy got %0d want 4", busy_cnt); else pass++;
    clear_log();
    send(8'h62); wait_idle(); idle(1);
    chk++; if (busy_cnt !== 2940) $display("FAIL wait62_busy got %0d want 2940", busy_cnt); else pass++;
    chk++; if (wr_cyc_q.size() !== 0) $display("FAIL wait_nowrite got %0d want 0", wr_cyc_q.size()); else pass++;
  endtask

  task automatic test_stall();
    int post;
    clear_log();
    send(8'hB3); idle(3);
    send(8'h07); idle(2);
    chk++; if (wr_cyc_q.size() !== 0) $display("FAIL stall_early got %0d want 0", wr_cyc_q.size()); else pass++;
    send(8'h3C);
    post = last_post;
    idle(4);
    chk++; if (wr_cyc_q.size() !== 1) $display("FAIL stall_count got %0d want 1", wr_cyc_q.size()); else pass++;
    if (wr_cyc_q.size() == 1) begin
      chk++; if (wr_reg_q[0] !== 6'h07 || wr_val_q[0] !== 8'h3C)
        $display("FAIL stall_write got %h/%h want 07/3c", wr_reg_q[0], wr_val_q[0]); else pass++;
      chk++; if (wr_cyc_q[0] !== post) $display("FAIL stall_lat got %0d want %0d", wr_cyc_q[0], post); else pass++;
    end
  endtask

  task automatic test_drop_done();
    clear_log();
    send(8'hB3); send(8'h45); send(8'hAA); send(8'h66);
    in_data = 8'hB3;
    in_valid = 1'b1;
    repeat (6) begin
      @(posedge in_clk);
      #1;
    end
    in_valid = 1'b0;
    chk++; if (wr_cyc_q.size() !== 0) $display("FAIL drop_count got %0d want 0", wr_cyc_q.size()); else pass++;
    chk++; if (out_done !== 1'b1) $display("FAIL done_flag got %b want 1", out_done); else pass++;
    chk++; if (out_ready !== 1'b0) $display("FAIL done_ready got %b want 0", out_ready); else pass++;
    chk++; if (out_err !== 1'b0) $display("FAIL done_err got %b want 0", out_err); else pass++;
  endtask

  task automatic test_err();
    do_reset();
    clear_log();
    send(8'h4F);
    idle(3);
    chk++; if (out_err !== 1'b1) $display("FAIL err_flag got %b want 1", out_err); else pass++;
    chk++; if (out_ready !== 1'b0) $display("FAIL err_ready got %b want 0", out_ready); else pass++;
    chk++; if (out_done !== 1'b0) $display("FAIL err_done got %b want 0", out_done); else pass++;
    chk++; if (wr_cyc_q.size() !== 0) $display("FAIL err_count got %0d want 0", wr_cyc_q.size()); else pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_log();
    send(8'h61); send(8'h10); send(8'h00);
    idle(5);
    chk++; if (out_busy !== 1'b1) $display("FAIL midwait_pre got %b want 1", out_busy); else pass++;
    in_rst = 1'b1;
    #1;
    chk++; if (out_busy !== 1'b0) $display("FAIL midwait_busy got %b want 0", out_busy); else pass++;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    idle(1);
    send(8'hB3); send(8'h0A); send(8'h5A);
    chk++; if (out_wr !== 1'b1) $display("FAIL midwr_pre got %b want 1", out_wr); else pass++;
    in_rst = 1'b1;
    #1;
    chk++; if (out_wr !== 1'b0 || out_reg !== 6'h00 || out_val !== 8'h00)
      $display("FAIL midwr_outs got wr=%b reg=%h val=%h want 0/00/00", out_wr, out_reg, out_val); else pass++;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    idle(3);
    chk++; if (wr_cyc_q.size() !== 0) $display("FAIL midwr_replay got %0d want 0", wr_cyc_q.size()); else pass++;
    send(8'hB3); send(8'h00); send(8'hFF);
    idle(4);
    chk++; if (wr_cyc_q.size() !== 1) $display("FAIL post_rst_count got %0d want 1", wr_cyc_q.size()); else pass++;
    if (wr_cyc_q.size() == 1) begin
      chk++; if (wr_reg_q[0] !== 6'h00 || wr_val_q[0] !== 8'hFF)
        $display("FAIL post_rst_write got %h/%h want 00/ff", wr_reg_q[0], wr_val_q[0]); else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_n();
    test_wait_short();
    test_stall();
    test_drop_done();
    test_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
